fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

Drain-side consumer for the team's synchronous FIFO: pops words from a registered-read FIFO and serialises each as an asynchronous UART frame on a single line. It sits between a FIFO's read port (`rd`/`empty`/data) and an off-chip TX pin. It issues exactly one FIFO read per frame.

## Interface
Parameters:
- `DWIDTH`, 8, data bits per frame; matches the FIFO data width.
- `CLKS_PER_BIT`, 16, clk cycles per bit period; must be ≥ 2.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `en`  in  1  start enable, sampled only in IDLE.
- `fifo_empty`  in  1  upstream FIFO empty flag.
- `fifo_data`  in  DWIDTH  upstream FIFO read data. Valid the cycle after the `fifo_rd` cycle (one-cycle read latency).
- `fifo_rd`  out  1  read strobe, one cycle per frame.
- `tx`  out  1  serial line; idle high.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- Moore FSM with states IDLE, FETCH, LOAD, START, DATA, PARITY (only with the macro), STOP.
- **IDLE:**
  - `tx`=1.
  - If `en`=1 and `fifo_empty`=0, go to FETCH.
  - Otherwise stay in IDLE.
- **FETCH:**
  - One cycle. `fifo_rd`=1, decoded from the state register.
  - Always goes to LOAD. `en` and `fifo_empty` are ignored here.
- **LOAD:**
  - One cycle. The shift register captures `fifo_data`.
  - The bit index and the baud counter clear.
  - Go to START.
- **START:** `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- **DATA:**
  - Sends `DWIDTH` bits, LSB first, each held `CLKS_PER_BIT` cycles.
  - The shift register shifts right at each bit boundary.
  - After bit `DWIDTH-1`, go to PARITY if the macro is defined, else STOP.
- **PARITY:** `tx` = XOR of all data bits (even parity), held `CLKS_PER_BIT` cycles, then go to STOP.
- **STOP:** `tx`=1 for `CLKS_PER_BIT` cycles, then go to IDLE.
- **Counters:**
  - The baud counter is `$clog2(CLKS_PER_BIT)` bits wide.
  - It counts 0…`CLKS_PER_BIT-1` and wraps to 0 at each bit boundary.
  - The bit index is `$clog2(DWIDTH)`+1 bits wide. It never wraps within a frame.
- **`en` deasserted mid-frame:** the current frame completes. No new FETCH is issued.
- **`fifo_empty` rising mid-frame:** no effect. The flag is re-checked only in IDLE.
- **Reset mid-frame:** the frame aborts immediately and `tx` goes high. The captured word is lost and is not re-read.

## Timing
- Reset values: `tx`=1, `fifo_rd`=0, `busy`=0, state=IDLE, counters=0.
- All outputs are registered or decoded from registered state. There is no combinational path from any input to any output.
- Cycle of the IDLE→FETCH transition edge = T. Then:
  - `fifo_rd` is high during cycle T+1.
  - Data is captured at the end of T+2.
  - `tx` falls at the start of T+3.
- Frame length is `(DWIDTH+2)·CLKS_PER_BIT` cycles, or `(DWIDTH+3)·CLKS_PER_BIT` with parity.
- Back-to-back frames:
  - The minimum idle-high gap between the end of STOP and the next start bit is 3 cycles (IDLE, FETCH, LOAD).
  - `busy` stays high through FETCH and LOAD. It drops for exactly 1 cycle (IDLE) between frames.
- `fifo_rd` is never high for two consecutive cycles, and never while `fifo_empty` was high at the IDLE decision.

## Configuration
- Macro `FIFO_UART_TX_PARITY_EN`.
- **Defined:** the PARITY state is compiled in. Each frame carries one even-parity bit between the last data bit and stop.
- **Undefined:** the PARITY state and parity logic are absent. DATA goes directly to STOP.

## Test plan
- **Single word:** `DWIDTH`=8, `CLKS_PER_BIT`=4, FIFO holds 0xA5, `en`=1.
  - Expect one `fifo_rd` pulse.
  - `tx` sequence per 4-cycle bit: 0, 1,0,1,0,0,1,0,1, 1.
  - With parity: parity bit 0 inserted before stop.
  - `busy` low 1 cycle after stop ends.
- **Back-to-back:** FIFO holds 0x01 then 0xFF.
  - Expect exactly two `fifo_rd` pulses.
  - Exactly 3 high cycles between the first stop end and the second start.
  - Second frame data bits are all 1. With parity, its parity bit is 0.
- **Empty FIFO:** `fifo_empty`=1, `en`=1 for 100 cycles.
  - `fifo_rd` never asserts.
  - `tx`=1 and `busy`=0 throughout.
- **Enable drop:** FIFO holds 3 words. Drop `en` during the DATA bit 3 of frame 1.
  - Frame 1 completes intact.
  - No further `fifo_rd`; two words remain in the FIFO.
- **Reset mid-frame:** assert `rst` during the DATA bit 5 of 0x3C.
  - `tx`=1, `busy`=0, `fifo_rd`=0 immediately, without waiting for a clock edge.
  - After release with `en`=1 and the FIFO non-empty, the next word is fetched. The partial word is not resent.
- **Parity sweep (macro defined):** send 0x00, 0x07, 0x80.
  - Parity bits are 0, 1, 1.
  - Each frame is 44 cycles long at `CLKS_PER_BIT`=4.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// Pops one word per frame from a registered-read FIFO and serialises it LSB-first as a UART frame.
// Optional even-parity bit is compiled in when FIFO_UART_TX_PARITY_EN is defined.
module fifo_uart_tx #(
    parameter int DWIDTH       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              fifo_empty,
    input  logic [DWIDTH-1:0] fifo_data,
    output logic              fifo_rd,
    output logic              tx,
    output logic              busy
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DWIDTH) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DWIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_START,
        S_DATA,
`ifdef FIFO_UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DWIDTH-1:0]   shift_q, shift_d;
    logic                bit_done;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                parity_q, parity_d;
`endif

    assign bit_done = (baud_q == BAUD_LAST);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (en && !fifo_empty) state_d = S_FETCH;
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                shift_d  = fifo_data;
                bit_d    = '0;
                baud_d   = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                parity_d = ^fifo_data;
`endif
                state_d  = S_START;
            end
            S_START: begin
                baud_d = bit_done ? '0 : baud_q + BAUD_W'(1);
                if (bit_done) state_d = S_DATA;
            end
            S_DATA: begin
                baud_d = bit_done ? '0 : baud_q + BAUD_W'(1);
                if (bit_done) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: begin
                baud_d = bit_done ? '0 : baud_q + BAUD_W'(1);
                if (bit_done) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                baud_d = bit_done ? '0 : baud_q + BAUD_W'(1);
                if (bit_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Outputs decode registered state only, so reset forces the line high without a clock.
    always_comb begin
        tx = 1'b1;
        unique case (state_q)
            S_START:  tx = 1'b0;
            S_DATA:   tx = shift_q[0];
`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: tx = parity_q;
`endif
            default:  tx = 1'b1;
        endcase
    end

    assign fifo_rd = (state_q == S_FETCH);
    assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a queue-based FIFO plus expected-line model checked every cycle,
// with literal frame/spacing expectations; honours FIFO_UART_TX_PARITY_EN.
module tb_fifo_uart_tx;

    localparam int DW  = 8;
    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NB = 11;
    localparam logic [10:0] F_A5 = 11'h54A;
    localparam logic [10:0] F_01 = 11'h602;
    localparam logic [10:0] F_FF = 11'h5FE;
    localparam int          RD_SPACING = 47;
`else
    localparam int NB = 10;
    localparam logic [10:0] F_A5 = 11'h34A;
    localparam logic [10:0] F_01 = 11'h202;
    localparam logic [10:0] F_FF = 11'h3FE;
    localparam int          RD_SPACING = 43;
`endif

    logic          clk = 1'b0;
    logic          rst, en, fifo_empty;
    logic [DW-1:0] fifo_data;
    logic          fifo_rd, tx, busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] fifo_q[$];
    bit         stream[$];
    int         rd_cyc[$];
    logic [7:0] popped[$];
    int         cyc = 0;
    bit         idle_go = 1'b0;

    fifo_uart_tx #(.DWIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_rd(fifo_rd), .tx(tx), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a fetch follows any idle cycle with en=1 and a non-empty FIFO; each fetched
    // word then dictates the exact line level for every following cycle of its frame.
    always @(negedge clk) begin : monitor
        bit         exp_rd, had;
        logic [7:0] w;
        cyc++;
        if (rst) begin
            check("rst_tx", tx, 1);
            check("rst_busy", busy, 0);
            check("rst_fifo_rd", fifo_rd, 0);
            stream.delete();
            idle_go = 1'b0;
        end else begin
            exp_rd = idle_go;
            had    = (stream.size() != 0);
            check("fifo_rd", fifo_rd, exp_rd);
            check("tx", tx, had ? stream[0] : 1'b1);
            check("busy", busy, exp_rd || had);
            if (had) void'(stream.pop_front());
            if (exp_rd) begin
                w = fifo_q.pop_front();
                fifo_data = w;
                popped.push_back(w);
                rd_cyc.push_back(cyc);
                stream.push_back(1'b1);
                repeat (CPB) stream.push_back(1'b0);
                for (int i = 0; i < DW; i++) repeat (CPB) stream.push_back(w[i]);
`ifdef FIFO_UART_TX_PARITY_EN
                repeat (CPB) stream.push_back(^w);
`endif
                repeat (CPB) stream.push_back(1'b1);
            end
            idle_go = !exp_rd && !had && en && (fifo_q.size() != 0);
        end
        fifo_empty = (fifo_q.size() == 0);
    end

    // Samples each bit of the next frame at one cycle past its start.
    task automatic capture_frame(output logic [10:0] f);
        int n = 0;
        f = '0;
        @(negedge clk);
        while (tx !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("start_bit_timeout", n < 400, 1);
        @(negedge clk);
        f[0] = tx;
        for (int k = 1; k < NB; k++) begin
            repeat (CPB) @(negedge clk);
            f[k] = tx;
        end
    endtask

    task automatic wait_rd(input int start);
        int n = 0;
        while (rd_cyc.size() <= start && n < 300) begin
            @(posedge clk);
            n++;
        end
        check("fifo_rd_timeout", rd_cyc.size() > start, 1);
    endtask

    task automatic load_words(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input int n);
        @(posedge clk);
        #1 en = 1'b0;
        fifo_q.push_back(a);
        if (n > 1) fifo_q.push_back(b);
        if (n > 2) fifo_q.push_back(c);
        repeat (2) @(posedge clk);
        #1 en = 1'b1;
    endtask

    initial begin
        logic [10:0] f;
        int          base;
        rst = 1'b1; en = 1'b0; fifo_empty = 1'b1; fifo_data = '0;
        #1;
        check("reset_tx", tx, 1);
        check("reset_busy", busy, 0);
        check("reset_fifo_rd", fifo_rd, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single word
        load_words(8'hA5, 8'h00, 8'h00, 1);
        capture_frame(f);
        check("frame_a5", f, F_A5);
        repeat (10) @(posedge clk);
        check("a5_rd_count", rd_cyc.size(), 1);

        // Back-to-back
        load_words(8'h01, 8'hFF, 8'h00, 2);
        capture_frame(f);
        check("frame_01", f, F_01);
        capture_frame(f);
        check("frame_ff", f, F_FF);
        repeat (10) @(posedge clk);
        check("b2b_rd_count", rd_cyc.size(), 3);
        check("b2b_rd_spacing", rd_cyc[2] - rd_cyc[1], RD_SPACING);

        // Empty FIFO with en held high
        base = rd_cyc.size();
        repeat (100) @(posedge clk);
        check("empty_no_rd", rd_cyc.size(), base);

        // Enable dropped during data bit 3 of the first frame
        load_words(8'h11, 8'h22, 8'h33, 3);
        wait_rd(base);
        repeat (18) @(posedge clk);
        #1 en = 1'b0;
        repeat (60) @(posedge clk);
        check("endrop_rd_count", rd_cyc.size(), base + 1);
        check("endrop_word", popped[popped.size()-1], 8'h11);
        check("endrop_left", fifo_q.size(), 2);

        // Reset during data bit 5 of 0x3C
        @(posedge clk);
        #1 fifo_q.delete();
        base = rd_cyc.size();
        load_words(8'h3C, 8'h5A, 8'h00, 2);
        wait_rd(base);
        repeat (26) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst_tx", tx, 1);
        check("midrst_busy", busy, 0);
        check("midrst_fifo_rd", fifo_rd, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wait_rd(base + 1);
        repeat (50) @(posedge clk);
        check("postrst_word", popped[popped.size()-1], 8'h5A);
        check("postrst_rd_count", rd_cyc.size(), base + 2);
        check("postrst_left", fifo_q.size(), 0);

`ifdef FIFO_UART_TX_PARITY_EN
        // Parity sweep
        base = rd_cyc.size();
        load_words(8'h00, 8'h07, 8'h80, 3);
        capture_frame(f);
        check("par_frame_00", f, 11'h400);
        capture_frame(f);
        check("par_frame_07", f, 11'h60E);
        capture_frame(f);
        check("par_frame_80", f, 11'h700);
        repeat (10) @(posedge clk);
        check("par_rd_count", rd_cyc.size(), base + 3);
        check("par_spacing_1", rd_cyc[base+1] - rd_cyc[base], 47);
        check("par_spacing_2", rd_cyc[base+2] - rd_cyc[base+1], 47);
`endif

        @(posedge clk);
        #1 en = 1'b0;
        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
